// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline encodings for the hazard controller
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    STARTUP  = 2'b00,
    RUN      = 2'b01,
    MEM_WAIT = 2'b10
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // M is younger than W, so its result wins when both match.
  function automatic fwd_sel_e fwd_pick(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       wr_m,
    input logic [4:0] rd_w,
    input logic       wr_w
  );
    if (wr_m && rd_m != REG_X0 && rd_m == rs)
      return FWD_M;
    else if (wr_w && rd_w != REG_X0 && rd_w == rs)
      return FWD_W;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - EX-stage operand bypass selects
module forward_unit
  import riscv_pkg::*;
(
  input  logic [4:0] rs1_E,
  input  logic [4:0] rs2_E,
  input  logic [4:0] rd_M,
  input  logic       reg_wr_M,
  input  logic [4:0] rd_W,
  input  logic       reg_wr_W,
  output fwd_sel_e   fwd_a,
  output fwd_sel_e   fwd_b
);

  assign fwd_a = fwd_pick(rs1_E, rd_M, reg_wr_M, rd_W, reg_wr_W);
  assign fwd_b = fwd_pick(rs2_E, rd_M, reg_wr_M, rd_W, reg_wr_W);

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline stall/flush/forward controller with perf counters
module hazard_unit
  import riscv_pkg::*;
#(
  parameter int STARTUP_CYCLES = 4,
  parameter int MEM_TIMEOUT    = 64,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             reg_wr_E,
  input  logic [1:0]       sel_wb_E,
  input  logic             pc_redirect_E,
  input  logic [4:0]       rd_M,
  input  logic             reg_wr_M,
  input  logic             dmem_req_M,
  input  logic             dmem_ready,
  input  logic [4:0]       rd_W,
  input  logic             reg_wr_W,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             stall_W,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic             flush_W,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic [CNT_W-1:0] perf_stall_cycles,
  output logic [CNT_W-1:0] perf_flush_events,
  output logic             mem_timeout
);

  localparam int SU_W = $clog2(STARTUP_CYCLES + 1);
  localparam int WT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [SU_W-1:0] SU_LAST = SU_W'(STARTUP_CYCLES - 1);
  localparam logic [WT_W-1:0] WT_MAX  = WT_W'(MEM_TIMEOUT);

  hz_state_e       state_q, state_d;
  logic [SU_W-1:0] su_cnt_q, su_cnt_d;
  logic [WT_W-1:0] wt_cnt_q, wt_cnt_d;
  logic            redirect_flush;
  logic            mem_wait;
  logic            load_use;
  fwd_sel_e        fwd_a, fwd_b;

  forward_unit u_forward_unit (
    .rs1_E    (rs1_E),
    .rs2_E    (rs2_E),
    .rd_M     (rd_M),
    .reg_wr_M (reg_wr_M),
    .rd_W     (rd_W),
    .reg_wr_W (reg_wr_W),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b)
  );

  assign mem_wait = dmem_req_M && !dmem_ready;
  assign load_use = reg_wr_E && (sel_wb_E == WB_MEM) && (rd_E != REG_X0) &&
                    ((rd_E == rs1_D) || (rd_E == rs2_D));

  // Bypass paths carry scrub garbage during startup, so force the RF path.
  assign fwd_a_E = (state_q == STARTUP) ? FWD_RF : fwd_a;
  assign fwd_b_E = (state_q == STARTUP) ? FWD_RF : fwd_b;
  assign stall_W = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= STARTUP;
      su_cnt_q <= '0;
      wt_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      su_cnt_q <= su_cnt_d;
      wt_cnt_q <= wt_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    su_cnt_d       = su_cnt_q;
    wt_cnt_d       = wt_cnt_q;
    redirect_flush = 1'b0;
    stall_F        = 1'b0;
    stall_D        = 1'b0;
    stall_E        = 1'b0;
    stall_M        = 1'b0;
    flush_D        = 1'b0;
    flush_E        = 1'b0;
    flush_M        = 1'b0;
    flush_W        = 1'b0;
    case (state_q)
      STARTUP: begin
        stall_F  = 1'b1;
        flush_D  = 1'b1;
        flush_E  = 1'b1;
        flush_M  = 1'b1;
        flush_W  = 1'b1;
        su_cnt_d = su_cnt_q + SU_W'(1);
        if (su_cnt_q == SU_LAST)
          state_d = RUN;
      end
      RUN: begin
        if (mem_wait) begin
          stall_F  = 1'b1;
          stall_D  = 1'b1;
          stall_E  = 1'b1;
          stall_M  = 1'b1;
          flush_W  = 1'b1;
          state_d  = MEM_WAIT;
          wt_cnt_d = WT_W'(1);
        end else if (pc_redirect_E) begin
          // The D-stage consumer is wrong-path, so its load-use stall is moot.
          flush_D        = 1'b1;
          flush_E        = 1'b1;
          redirect_flush = 1'b1;
        end else if (load_use) begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          flush_E = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          stall_E = 1'b1;
          stall_M = 1'b1;
          flush_W = 1'b1;
          if (wt_cnt_q != WT_MAX)
            wt_cnt_d = wt_cnt_q + WT_W'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = STARTUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_events <= '0;
      mem_timeout       <= 1'b0;
    end else begin
      if (stall_F && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + CNT_W'(1);
      if (redirect_flush && perf_flush_events != '1)
        perf_flush_events <= perf_flush_events + CNT_W'(1);
      if (wt_cnt_d == WT_MAX)
        mem_timeout <= 1'b1;
    end
  end

endmodule
